// File: rtl/commit_trace_buffer_pkg.sv
// Shared widths and the packed trace record used by the commit trace buffer and its FIFO.
package trace_pkg;

    localparam int PC_W   = 32;
    localparam int OP_W   = 6;
    localparam int RD_W   = 5;
    localparam int DATA_W = 32;

    localparam logic [RD_W-1:0] REG_ZERO = 5'd0;
    localparam logic [15:0]     DROP_MAX = 16'hFFFF;

    // Field order fixes the 75-bit layout as {pc, opcode, rd, data}.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [OP_W-1:0]   opcode;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } trace_entry_t;

    localparam int ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Drain port of the commit trace buffer: FIFO head, occupancy and the consumer's ready.
interface commit_trace_buffer_if
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              trace_valid;
    logic              trace_ready;
    logic [PC_W-1:0]   trace_pc;
    logic [OP_W-1:0]   trace_opcode;
    logic [RD_W-1:0]   trace_rd;
    logic [DATA_W-1:0] trace_data;
    logic [CNT_W-1:0]  trace_count;

    modport master (
        output trace_valid,
        output trace_pc,
        output trace_opcode,
        output trace_rd,
        output trace_data,
        output trace_count,
        input  trace_ready
    );

    modport slave (
        input  trace_valid,
        input  trace_pc,
        input  trace_opcode,
        input  trace_rd,
        input  trace_data,
        input  trace_count,
        output trace_ready
    );

endinterface

// File: rtl/commit_trace_buffer_sync_fifo.sv
// First-word fall-through FIFO with registered storage; clear and reset empty it.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    input  logic [WIDTH-1:0]       wrData_i,
    output logic [WIDTH-1:0]       headData_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic             doPush;
    logic             doPop;

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign doPop  = pop_i && (count_q != '0) && !clear_i;
    assign doPush = push_i && !clear_i && ((count_q != FULL_COUNT) || doPop);

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wrData_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            unique case ({doPush, doPop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset, so an empty FIFO presents zeros instead of stale data.
    assign headData_o = (count_q != '0) ? mem_q[rdPtr_q] : '0;
    assign count_o    = count_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures retired register writes into a trace FIFO and flags a halted (non-advancing) PC.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int HALT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    prog_count,
    input  logic [OP_W-1:0]    instr_opcode,
    input  logic [RD_W-1:0]    write_reg_addr,
    input  logic [DATA_W-1:0]  write_reg_data,
    input  logic               clear,
    commit_trace_buffer_if.master trace,
    output logic               overflow,
    output logic [15:0]        drop_count,
    output logic               halted
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int STALL_W = $clog2(HALT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [STALL_W-1:0] HALT_LIMIT = STALL_W'(HALT_CYCLES);

    logic [PC_W-1:0]    prevPc_q;
    logic               prevValid_q;
    logic [STALL_W-1:0] stallCnt_q;
    logic [STALL_W-1:0] stallCnt_d;
    logic               halted_q;
    logic               overflow_q;
    logic [15:0]        dropCount_q;

    logic               cap;
    logic               pop;
    logic               push;
    logic               fifoValid;
    logic [CNT_W-1:0]   fifoCount;
    trace_entry_t       newEntry;
    trace_entry_t       headEntry;

    // The first post-reset cycle always counts as a new PC, even when it equals the reset prevPc.
    assign cap  = (write_reg_addr != REG_ZERO) && (!prevValid_q || (prog_count != prevPc_q));
    assign pop  = fifoValid && trace.trace_ready;
    assign push = cap && !clear && ((fifoCount != FULL_COUNT) || pop);

    assign newEntry = '{pc: prog_count, opcode: instr_opcode, rd: write_reg_addr, data: write_reg_data};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .pop_i      (pop),
        .clear_i    (clear),
        .wrData_i   (newEntry),
        .headData_o (headEntry),
        .count_o    (fifoCount)
    );

    always_comb begin
        stallCnt_d = '0;
        if (prevValid_q && (prog_count == prevPc_q)) begin
            stallCnt_d = (stallCnt_q == HALT_LIMIT) ? stallCnt_q : stallCnt_q + STALL_W'(1);
        end
    end

    // Halt tracking ignores clear; only reset disturbs it.
    always_ff @(posedge clk) begin
        if (rst) begin
            prevPc_q    <= '0;
            prevValid_q <= 1'b0;
            stallCnt_q  <= '0;
            halted_q    <= 1'b0;
            overflow_q  <= 1'b0;
            dropCount_q <= '0;
        end else begin
            prevPc_q    <= prog_count;
            prevValid_q <= 1'b1;
            stallCnt_q  <= stallCnt_d;
            halted_q    <= (stallCnt_d == HALT_LIMIT);
            if (clear) begin
                overflow_q  <= 1'b0;
                dropCount_q <= '0;
            end else if (cap && !push) begin
                overflow_q <= 1'b1;
                if (dropCount_q != DROP_MAX) begin
                    dropCount_q <= dropCount_q + 16'd1;
                end
            end
        end
    end

    assign fifoValid          = (fifoCount != '0);
    assign trace.trace_valid  = fifoValid;
    assign trace.trace_pc     = headEntry.pc;
    assign trace.trace_opcode = headEntry.opcode;
    assign trace.trace_rd     = headEntry.rd;
    assign trace.trace_data   = headEntry.data;
    assign trace.trace_count  = fifoCount;

    assign overflow   = overflow_q;
    assign drop_count = dropCount_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench: stimulus queues expected trace records, a negedge monitor checks each drained head.
module tb_commit_trace_buffer;

    localparam int DEPTH       = 16;
    localparam int HALT_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] prog_count;
    logic [5:0]  instr_opcode;
    logic [4:0]  write_reg_addr;
    logic [31:0] write_reg_data;
    logic        clear;
    logic        overflow;
    logic [15:0] drop_count;
    logic        halted;

    logic [74:0] sbQ [$];
    int          checks = 0;
    int          fails  = 0;

    commit_trace_buffer_if #(.DEPTH(DEPTH)) traceBus ();

    commit_trace_buffer #(
        .DEPTH       (DEPTH),
        .HALT_CYCLES (HALT_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .prog_count     (prog_count),
        .instr_opcode   (instr_opcode),
        .write_reg_addr (write_reg_addr),
        .write_reg_data (write_reg_data),
        .clear          (clear),
        .trace          (traceBus),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [74:0] actual, input logic [74:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [5:0] op, input logic [4:0] rd,
                                 input logic [31:0] data, input bit expectPush);
        prog_count     = pc;
        instr_opcode   = op;
        write_reg_addr = rd;
        write_reg_data = data;
        if (expectPush) sbQ.push_back({pc, op, rd, data});
        step();
    endtask

    task automatic drainAll(input string name);
        for (int i = 0; i < 40 && sbQ.size() != 0; i++) step();
        checkOutput(name, 75'(sbQ.size()), 75'd0);
    endtask

    // Monitor: every accepted head must match the oldest outstanding expected record.
    initial begin
        logic [74:0] expEntry;
        forever begin
            @(negedge clk);
            if (!rst && traceBus.trace_valid && traceBus.trace_ready) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_entry: actual pc=0x%0h expected=none", traceBus.trace_pc);
                end else begin
                    expEntry = sbQ.pop_front();
                    checkOutput("drain_entry", {traceBus.trace_pc, traceBus.trace_opcode,
                                                traceBus.trace_rd, traceBus.trace_data}, expEntry);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        traceBus.trace_ready = 1'b0;
        prog_count = '0; instr_opcode = '0; write_reg_addr = '0; write_reg_data = '0;
        step();
        step();
        checkOutput("reset_valid", 75'(traceBus.trace_valid), 75'd0);
        checkOutput("reset_count", 75'(traceBus.trace_count), 75'd0);
        checkOutput("reset_pc", 75'(traceBus.trace_pc), 75'd0);
        checkOutput("reset_overflow", 75'(overflow), 75'd0);
        checkOutput("reset_drop", 75'(drop_count), 75'd0);
        checkOutput("reset_halted", 75'(halted), 75'd0);

        $display("[TB] small program with consumer stalled");
        rst = 1'b0;
        applyStimulus(32'd0, 6'h23, 5'd2, 32'd100, 1'b1);
        applyStimulus(32'd4, 6'h00, 5'd4, 32'd535, 1'b1);
        applyStimulus(32'd8, 6'h08, 5'd4, 32'd461, 1'b1);
        checkOutput("count_after_three", 75'(traceBus.trace_count), 75'd3);
        applyStimulus(32'd8, 6'h08, 5'd4, 32'd461, 1'b0);
        applyStimulus(32'd12, 6'h2b, 5'd0, 32'd0, 1'b0);
        checkOutput("count_no_capture", 75'(traceBus.trace_count), 75'd3);
        traceBus.trace_ready = 1'b1;
        drainAll("drain_program");
        checkOutput("count_drained", 75'(traceBus.trace_count), 75'd0);
        checkOutput("overflow_clean", 75'(overflow), 75'd0);

        $display("[TB] overflow with DEPTH+3 captures");
        traceBus.trace_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++)
            applyStimulus(32'h100 + 32'(4 * i), 6'h00, 5'd5, 32'(i), i < DEPTH);
        checkOutput("full_count", 75'(traceBus.trace_count), 75'd16);
        checkOutput("full_overflow", 75'(overflow), 75'd1);
        checkOutput("full_drop", 75'(drop_count), 75'd3);
        checkOutput("full_head_pc", 75'(traceBus.trace_pc), 75'h100);

        $display("[TB] full FIFO capturing while draining");
        traceBus.trace_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus(32'h200 + 32'(4 * i), 6'h00, 5'd5, 32'h200 + 32'(i), 1'b1);
        checkOutput("stream_count", 75'(traceBus.trace_count), 75'd16);
        checkOutput("stream_drop", 75'(drop_count), 75'd3);
        for (int i = 0; i < 11; i++) applyStimulus(32'h20C, 6'h2b, 5'd0, 32'd0, 1'b0);
        traceBus.trace_ready = 1'b0;
        checkOutput("partial_count", 75'(traceBus.trace_count), 75'd5);
        checkOutput("partial_overflow", 75'(overflow), 75'd1);

        $display("[TB] clear with a capture in the same cycle");
        clear = 1'b1;
        applyStimulus(32'h300, 6'h00, 5'd5, 32'h300, 1'b0);
        clear = 1'b0;
        sbQ.delete();
        checkOutput("clear_count", 75'(traceBus.trace_count), 75'd0);
        checkOutput("clear_valid", 75'(traceBus.trace_valid), 75'd0);
        checkOutput("clear_overflow", 75'(overflow), 75'd0);
        checkOutput("clear_drop", 75'(drop_count), 75'd0);

        $display("[TB] halt detection");
        applyStimulus(32'h20, 6'h00, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(32'h20, 6'h00, 5'd0, 32'd0, 1'b0);
        checkOutput("halt_three_repeats", 75'(halted), 75'd0);
        applyStimulus(32'h20, 6'h00, 5'd0, 32'd0, 1'b0);
        checkOutput("halt_four_repeats", 75'(halted), 75'd1);
        applyStimulus(32'h24, 6'h00, 5'd0, 32'd0, 1'b0);
        checkOutput("halt_release", 75'(halted), 75'd0);

        $display("[TB] reset in the middle of a drain");
        for (int i = 0; i < 5; i++)
            applyStimulus(32'h400 + 32'(4 * i), 6'h08, 5'd6, 32'd100 + 32'(i), 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(32'h410, 6'h08, 5'd0, 32'd0, 1'b0);
        checkOutput("pre_rst_halted", 75'(halted), 75'd1);
        checkOutput("pre_rst_count", 75'(traceBus.trace_count), 75'd5);
        traceBus.trace_ready = 1'b1;
        step();
        step();
        rst = 1'b1;
        traceBus.trace_ready = 1'b0;
        step();
        sbQ.delete();
        checkOutput("rst_valid", 75'(traceBus.trace_valid), 75'd0);
        checkOutput("rst_count", 75'(traceBus.trace_count), 75'd0);
        checkOutput("rst_pc", 75'(traceBus.trace_pc), 75'd0);
        checkOutput("rst_overflow", 75'(overflow), 75'd0);
        checkOutput("rst_drop", 75'(drop_count), 75'd0);
        checkOutput("rst_halted", 75'(halted), 75'd0);

        $display("[TB] first cycle after reset captures even at pc 0");
        rst = 1'b0;
        traceBus.trace_ready = 1'b1;
        applyStimulus(32'd0, 6'h23, 5'd3, 32'd7, 1'b1);
        applyStimulus(32'd0, 6'h23, 5'd3, 32'd7, 1'b0);
        drainAll("drain_post_reset");
        checkOutput("final_count", 75'(traceBus.trace_count), 75'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
